// File: rtl/iv_port_pkg.sv
// Shared constants and types for the IV-bus peripheral bank.
// Status bit positions and the strobe sequencer state encoding live here.
package iv_port_pkg;

    localparam logic [7:0] IN_BASE        = 8'h80;
    localparam logic [7:0] RDATA_UNMAPPED = 8'hFF;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_OVR  = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } strobe_state_t;

endpackage

// File: rtl/iv_port_bank_if.sv
// IV-bus command/data bundle between the 8X305 side (master) and the bank (slave).
interface iv_port_bank_if;

    logic       sc;
    logic       wc;
    logic       lb;
    logic       rb;
    logic [7:0] iv_wdata;
    logic [7:0] iv_rdata;
    logic       iv_rdata_oe;

    modport master (
        output sc, wc, lb, rb, iv_wdata,
        input  iv_rdata, iv_rdata_oe
    );

    modport slave (
        input  sc, wc, lb, rb, iv_wdata,
        output iv_rdata, iv_rdata_oe
    );

endinterface

// File: rtl/iv_strobe_seq.sv
// Setup/pulse/hold strobe generator with a latched data byte and a sticky overrun flag.
// Each phase length is counted down from (length - 1) so a phase lasts exactly its cycle count.
module iv_strobe_seq
    import iv_port_pkg::*;
#(
    parameter int unsigned STROBE_SETUP = 2,
    parameter int unsigned STROBE_WIDTH = 4,
    parameter int unsigned STROBE_HOLD  = 2
) (
    input  logic       cmd_clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic [7:0] trigger_data,
    input  logic       status_clear,
    output logic       strobe,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] strobe_data
);

    localparam int unsigned MAX_SW  = (STROBE_SETUP > STROBE_WIDTH) ? STROBE_SETUP : STROBE_WIDTH;
    localparam int unsigned CNT_MAX = (MAX_SW > STROBE_HOLD) ? MAX_SW : STROBE_HOLD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    strobe_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             ovr_q, ovr_d;

    always_ff @(posedge cmd_clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (status_clear) ovr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(STROBE_SETUP - 1);
                    data_d  = trigger_data;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(STROBE_WIDTH - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(STROBE_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A dropped trigger outranks a same-cycle status clear.
        if (trigger && (state_q != IDLE)) ovr_d = 1'b1;
    end

    assign strobe      = (state_q == PULSE);
    assign busy        = (state_q != IDLE);
    assign overrun     = ovr_q;
    assign strobe_data = data_q;

endmodule

// File: rtl/iv_port_bank.sv
// IV-bus peripheral bank: address latch, left-bank RAM, right-bank output/input ports.
// Define IV_PORT_STROBE_EN to build the hardware strobe sequencer behind address NUM_OUT.
module iv_port_bank
    import iv_port_pkg::*;
#(
    parameter int unsigned RAM_DEPTH    = 256,
    parameter int unsigned NUM_OUT      = 4,
    parameter int unsigned NUM_IN       = 2,
    parameter int unsigned STROBE_SETUP = 2,
    parameter int unsigned STROBE_WIDTH = 4,
    parameter int unsigned STROBE_HOLD  = 2
) (
    input  logic                  cmd_clk,
    input  logic                  rst,
    iv_port_bank_if.slave         bus,
    input  logic [8*NUM_IN-1:0]   in_port,
    output logic [8*NUM_OUT-1:0]  out_port,
    output logic [7:0]            strobe_data,
    output logic                  strobe,
    output logic                  strobe_busy,
    output logic [7:0]            addr
);

    localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    if (RAM_DEPTH < 2 || RAM_DEPTH > 256 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0 ||
        NUM_OUT < 1 || NUM_OUT > 8 || NUM_IN < 1 || NUM_IN > 8 ||
        STROBE_SETUP < 1 || STROBE_WIDTH < 1 || STROBE_HOLD < 1) begin : g_bad_cfg
        $error("iv_port_bank: illegal parameter set");
    end

    logic                wc_q;
    logic [7:0]          addr_q;
    logic [7:0]          out_q [NUM_OUT];
    logic [8*NUM_IN-1:0] sync1_q, sync2_q;
    logic [7:0]          ram [RAM_DEPTH];
    logic [7:0]          rdata_q, rdata_d;
    logic                oe_q;
    logic                overrun;
    logic [7:0]          status;

    logic wr_fire, rd_fire, rb_sel, st_sel;

    // sc wins over wc; wc_q resets high so a held wc cannot write on reset release.
    assign wr_fire = bus.wc & ~wc_q & ~bus.sc;
    assign rd_fire = (bus.lb | bus.rb) & ~bus.sc & ~bus.wc;
    assign rb_sel  = bus.rb & ~bus.lb;
    assign st_sel  = rb_sel & (addr_q == 8'(NUM_OUT));

    always_ff @(posedge cmd_clk) begin
        if (rst) begin
            wc_q    <= 1'b1;
            addr_q  <= 8'hFF;
            for (int i = 0; i < NUM_OUT; i++) out_q[i] <= 8'h00;
            sync1_q <= '0;
            sync2_q <= '0;
            rdata_q <= RDATA_UNMAPPED;
            oe_q    <= 1'b0;
        end else begin
            wc_q <= bus.wc;
            if (bus.sc) addr_q <= bus.iv_wdata;
            if (wr_fire && rb_sel) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (addr_q == 8'(i)) out_q[i] <= bus.iv_wdata;
                end
            end
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            rdata_q <= rdata_d;
            oe_q    <= rd_fire;
        end
    end

    always_ff @(posedge cmd_clk) begin
        if (!rst && wr_fire && bus.lb) ram[addr_q[RAM_AW-1:0]] <= bus.iv_wdata;
    end

    always_comb begin
        status          = 8'h00;
        status[ST_BUSY] = strobe_busy;
        status[ST_OVR]  = overrun;
    end

    always_comb begin
        rdata_d = RDATA_UNMAPPED;
        if (rd_fire) begin
            if (bus.lb) begin
                rdata_d = ram[addr_q[RAM_AW-1:0]];
            end else begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (addr_q == 8'(i)) rdata_d = out_q[i];
                end
                if (st_sel) rdata_d = status;
                for (int k = 0; k < NUM_IN; k++) begin
                    if (addr_q == IN_BASE + 8'(k)) rdata_d = sync2_q[8*k +: 8];
                end
            end
        end
    end

`ifdef IV_PORT_STROBE_EN
    logic trigger, status_clear;

    assign trigger      = wr_fire & st_sel;
    assign status_clear = rd_fire & st_sel;

    iv_strobe_seq #(
        .STROBE_SETUP (STROBE_SETUP),
        .STROBE_WIDTH (STROBE_WIDTH),
        .STROBE_HOLD  (STROBE_HOLD)
    ) u_strobe_seq (
        .cmd_clk      (cmd_clk),
        .rst          (rst),
        .trigger      (trigger),
        .trigger_data (bus.iv_wdata),
        .status_clear (status_clear),
        .strobe       (strobe),
        .busy         (strobe_busy),
        .overrun      (overrun),
        .strobe_data  (strobe_data)
    );
`else
    assign strobe      = 1'b0;
    assign strobe_busy = 1'b0;
    assign overrun     = 1'b0;
    assign strobe_data = 8'h00;
`endif

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_port[8*g +: 8] = out_q[g];
    end

    assign addr            = addr_q;
    assign bus.iv_rdata    = rdata_q;
    assign bus.iv_rdata_oe = oe_q;

endmodule

// File: tb/tb_iv_port_bank.sv
// Self-checking bench for iv_port_bank: directed scenarios plus randomized bus traffic
// compared against a transaction-level model of RAM, ports and inputs.
module tb_iv_port_bank;

    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned NUM_OUT   = 4;
    localparam int unsigned NUM_IN    = 2;
    localparam int unsigned S_SETUP   = 2;
    localparam int unsigned S_WIDTH   = 4;
    localparam int unsigned S_HOLD    = 2;

`ifdef IV_PORT_STROBE_EN
    localparam bit STROBE_ON = 1'b1;
`else
    localparam bit STROBE_ON = 1'b0;
`endif

    logic                  cmd_clk = 1'b0;
    logic                  rst;
    logic [8*NUM_IN-1:0]   in_port;
    logic [8*NUM_OUT-1:0]  out_port;
    logic [7:0]            strobe_data;
    logic                  strobe;
    logic                  strobe_busy;
    logic [7:0]            addr;

    iv_port_bank_if bus ();

    iv_port_bank #(
        .RAM_DEPTH    (RAM_DEPTH),
        .NUM_OUT      (NUM_OUT),
        .NUM_IN       (NUM_IN),
        .STROBE_SETUP (S_SETUP),
        .STROBE_WIDTH (S_WIDTH),
        .STROBE_HOLD  (S_HOLD)
    ) dut (
        .cmd_clk     (cmd_clk),
        .rst         (rst),
        .bus         (bus),
        .in_port     (in_port),
        .out_port    (out_port),
        .strobe_data (strobe_data),
        .strobe      (strobe),
        .strobe_busy (strobe_busy),
        .addr        (addr)
    );

    always #5 cmd_clk = ~cmd_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram_m [RAM_DEPTH];
    bit         ram_v [RAM_DEPTH];
    logic [7:0] out_m [NUM_OUT];
    logic [7:0] in_m  [NUM_IN];
    logic [7:0] addr_m;

    // ---------------- model ----------------
    function automatic logic [8*NUM_OUT-1:0] model_out();
        logic [8*NUM_OUT-1:0] v;
        for (int i = 0; i < NUM_OUT; i++) v[8*i +: 8] = out_m[i];
        return v;
    endfunction

    function automatic logic [7:0] model_rb(input logic [7:0] a);
        int ai = int'(a);
        if (ai < NUM_OUT) return out_m[ai];
        if (ai >= 128 && ai - 128 < NUM_IN) return in_m[ai - 128];
        return 8'hFF;
    endfunction

    function automatic void model_write(input logic l, input logic r, input logic [7:0] d);
        int ai = int'(addr_m);
        if (l) begin
            ram_m[ai % RAM_DEPTH] = d;
            ram_v[ai % RAM_DEPTH] = 1'b1;
        end else if (r && ai < NUM_OUT) begin
            out_m[ai] = d;
        end
    endfunction

    function automatic void model_reset();
        addr_m = 8'hFF;
        for (int i = 0; i < NUM_OUT; i++) out_m[i] = 8'h00;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic drive_inputs();
        for (int k = 0; k < NUM_IN; k++) in_port[8*k +: 8] = in_m[k];
    endtask

    task automatic do_select(input logic [7:0] a);
        bus.sc = 1'b1;
        bus.iv_wdata = a;
        @(negedge cmd_clk);
        bus.sc = 1'b0;
        addr_m = a;
    endtask

    task automatic do_write(input logic l, input logic r, input logic [7:0] d, input int hold);
        bus.lb = l;
        bus.rb = r;
        bus.wc = 1'b1;
        bus.iv_wdata = d;
        repeat (hold) @(negedge cmd_clk);
        bus.wc = 1'b0;
        bus.lb = 1'b0;
        bus.rb = 1'b0;
        @(negedge cmd_clk);
    endtask

    task automatic do_read(input logic l, input logic r, output logic [7:0] d, output logic oe);
        bus.lb = l;
        bus.rb = r;
        bus.sc = 1'b0;
        bus.wc = 1'b0;
        @(negedge cmd_clk);
        d  = bus.iv_rdata;
        oe = bus.iv_rdata_oe;
        bus.lb = 1'b0;
        bus.rb = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.sc = 1'b0; bus.wc = 1'b0; bus.lb = 1'b0; bus.rb = 1'b0;
        bus.iv_wdata = 8'h00;
        for (int k = 0; k < NUM_IN; k++) in_m[k] = 8'h00;
        for (int i = 0; i < RAM_DEPTH; i++) ram_v[i] = 1'b0;
        drive_inputs();
        repeat (3) @(negedge cmd_clk);
        total++; if (addr !== 8'hFF) begin bad++; $display("FAIL reset_addr: got %h want ff", addr); end
        total++; if (out_port !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", out_port); end
        total++; if (strobe !== 1'b0 || strobe_busy !== 1'b0) begin
            bad++; $display("FAIL reset_strobe: got %b%b want 00", strobe, strobe_busy);
        end
        total++; if (strobe_data !== 8'h00) begin bad++; $display("FAIL reset_sdata: got %h want 00", strobe_data); end
        total++; if (bus.iv_rdata !== 8'hFF || bus.iv_rdata_oe !== 1'b0) begin
            bad++; $display("FAIL reset_rdata: got %h/%b want ff/0", bus.iv_rdata, bus.iv_rdata_oe);
        end
        rst = 1'b0;
        model_reset();
        @(negedge cmd_clk);
    endtask

    task automatic test_ram();
        logic [7:0] d;
        logic       oe;
        do_select(8'h05);
        total++; if (addr !== 8'h05) begin bad++; $display("FAIL ram_addr: got %h want 05", addr); end
        do_write(1'b1, 1'b0, 8'hA5, 1); model_write(1'b1, 1'b0, 8'hA5);
        do_read(1'b1, 1'b0, d, oe);
        total++; if (d !== 8'hA5 || oe !== 1'b1) begin
            bad++; $display("FAIL ram_read: got %h/%b want a5/1", d, oe);
        end
        @(negedge cmd_clk);
        total++; if (bus.iv_rdata_oe !== 1'b0) begin bad++; $display("FAIL ram_oe_off: got %b want 0", bus.iv_rdata_oe); end
        // 0x15 aliases 0x05 in a 16-byte RAM
        do_select(8'h15);
        do_write(1'b1, 1'b0, 8'h3B, 2); model_write(1'b1, 1'b0, 8'h3B);
        do_select(8'h07);
        do_write(1'b1, 1'b0, 8'h70, 1); model_write(1'b1, 1'b0, 8'h70);
        // sc with wc: latch only, then a held wc must not write at the new address
        bus.sc = 1'b1; bus.wc = 1'b1; bus.lb = 1'b1; bus.iv_wdata = 8'h05;
        @(negedge cmd_clk);
        bus.sc = 1'b0; bus.iv_wdata = 8'hEE; addr_m = 8'h05;
        @(negedge cmd_clk);
        bus.wc = 1'b0; bus.lb = 1'b0;
        @(negedge cmd_clk);
        do_read(1'b1, 1'b0, d, oe);
        total++; if (d !== ram_m[5]) begin bad++; $display("FAIL ram_alias_held: got %h want %h", d, ram_m[5]); end
        do_select(8'h07);
        do_read(1'b1, 1'b0, d, oe);
        total++; if (d !== ram_m[7]) begin bad++; $display("FAIL ram_sc_wins: got %h want %h", d, ram_m[7]); end
    endtask

    task automatic test_out_port();
        logic [7:0] d;
        logic       oe;
        do_select(8'h02);
        bus.rb = 1'b1; bus.wc = 1'b1; bus.iv_wdata = 8'h3C;
        for (int c = 1; c <= 5; c++) begin
            @(negedge cmd_clk);
            total++; if (out_port[23:16] !== 8'h3C) begin
                bad++; $display("FAIL out_once c=%0d: got %h want 3c", c, out_port[23:16]);
            end
            d = 8'($urandom);
            bus.iv_wdata = (d == 8'h3C) ? 8'h00 : d;
        end
        bus.wc = 1'b0; bus.rb = 1'b0;
        @(negedge cmd_clk);
        model_write(1'b0, 1'b1, 8'h3C);
        do_write(1'b0, 1'b1, 8'h99, 3); model_write(1'b0, 1'b1, 8'h99);
        total++; if (out_port !== model_out()) begin bad++; $display("FAIL out_rehold: got %h want %h", out_port, model_out()); end
        do_read(1'b0, 1'b1, d, oe);
        total++; if (d !== 8'h99 || oe !== 1'b1) begin bad++; $display("FAIL out_readback: got %h/%b want 99/1", d, oe); end
        // lb outranks rb; unmapped right-bank writes are dropped
        do_select(8'h01);
        do_write(1'b1, 1'b1, 8'h4D, 1); model_write(1'b1, 1'b1, 8'h4D);
        do_select(8'h80);
        do_write(1'b0, 1'b1, 8'h12, 1); model_write(1'b0, 1'b1, 8'h12);
        do_select(8'h06);
        do_write(1'b0, 1'b1, 8'h34, 1); model_write(1'b0, 1'b1, 8'h34);
        total++; if (out_port !== model_out()) begin bad++; $display("FAIL out_ignored: got %h want %h", out_port, model_out()); end
    endtask

    task automatic test_in_port();
        logic [7:0] d;
        logic       oe;
        do_select(8'h81);
        in_m[1] = 8'h5A;
        drive_inputs();
        bus.rb = 1'b1;
        @(negedge cmd_clk);
        @(negedge cmd_clk);
        total++; if (bus.iv_rdata !== 8'h00) begin bad++; $display("FAIL in_early: got %h want 00", bus.iv_rdata); end
        @(negedge cmd_clk);
        total++; if (bus.iv_rdata !== 8'h5A) begin bad++; $display("FAIL in_latency: got %h want 5a", bus.iv_rdata); end
        bus.rb = 1'b0;
        @(negedge cmd_clk);
        do_select(8'h90);
        do_read(1'b0, 1'b1, d, oe);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL in_unmapped90: got %h want ff", d); end
        do_select(8'h82);
        do_read(1'b0, 1'b1, d, oe);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL in_unmapped82: got %h want ff", d); end
        do_select(8'h05);
        do_read(1'b0, 1'b1, d, oe);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL rb_unmapped05: got %h want ff", d); end
    endtask

    task automatic test_strobe();
        bit         exp_strobe, exp_busy;
        logic [7:0] exp_sdata;
        logic [8*NUM_OUT-1:0] ports;
        ports = model_out();
        do_select(8'(NUM_OUT));
        bus.rb = 1'b1; bus.wc = 1'b1; bus.iv_wdata = 8'h41;
        for (int k = 1; k <= 12; k++) begin
            @(negedge cmd_clk);
            exp_strobe = STROBE_ON && (k >= 1 + S_SETUP) && (k <= S_SETUP + S_WIDTH);
            exp_busy   = STROBE_ON && (k <= S_SETUP + S_WIDTH + S_HOLD);
            exp_sdata  = STROBE_ON ? 8'h41 : 8'h00;
            total++; if (strobe !== exp_strobe || strobe_busy !== exp_busy) begin
                bad++; $display("FAIL strobe_k%0d: got s=%b b=%b want s=%b b=%b",
                                k, strobe, strobe_busy, exp_strobe, exp_busy);
            end
            if (exp_busy || !STROBE_ON) begin
                total++; if (strobe_data !== exp_sdata) begin
                    bad++; $display("FAIL sdata_k%0d: got %h want %h", k, strobe_data, exp_sdata);
                end
            end
            if (k == 6) begin
                total++; if (bus.iv_rdata !== (STROBE_ON ? 8'h03 : 8'h00) || bus.iv_rdata_oe !== 1'b1) begin
                    bad++; $display("FAIL status_busy: got %h/%b want %h/1", bus.iv_rdata,
                                    bus.iv_rdata_oe, STROBE_ON ? 8'h03 : 8'h00);
                end
            end
            if (k == 11) begin
                total++; if (bus.iv_rdata !== 8'h00) begin
                    bad++; $display("FAIL status_cleared: got %h want 00", bus.iv_rdata);
                end
            end
            // second trigger in PULSE, status reads in PULSE and after idle
            bus.wc = (k == 3);
            bus.rb = (k == 3) || (k == 5) || (k == 10);
            bus.iv_wdata = (k == 3) ? 8'h99 : 8'h00;
        end
        bus.wc = 1'b0; bus.rb = 1'b0;
        total++; if (out_port !== ports) begin bad++; $display("FAIL strobe_ports: got %h want %h", out_port, ports); end
    endtask

    task automatic test_random();
        logic [7:0] a, d, exp;
        logic       l, r, oe;
        int         op;
        do_select(8'h00);
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    case ($urandom_range(0, 3))
                        0: a = 8'($urandom_range(0, NUM_OUT - 1));
                        1: a = 8'($urandom_range(8'h80, 8'h82));
                        default: a = 8'($urandom);
                    endcase
                    if (a == 8'(NUM_OUT)) a = 8'h81;
                    do_select(a);
                end
                1: begin
                    l = 1'($urandom); r = 1'($urandom); d = 8'($urandom);
                    do_write(l, r, d, $urandom_range(1, 3));
                    model_write(l, r, d);
                    total++; if (out_port !== model_out()) begin
                        bad++; $display("FAIL rnd_write n=%0d: got %h want %h", n, out_port, model_out());
                    end
                end
                2: begin
                    l = 1'($urandom); r = l ? 1'($urandom) : 1'b1;
                    do_read(l, r, d, oe);
                    exp = l ? ram_m[int'(addr_m) % RAM_DEPTH] : model_rb(addr_m);
                    if (!l || ram_v[int'(addr_m) % RAM_DEPTH]) begin
                        total++; if (d !== exp || oe !== 1'b1) begin
                            bad++; $display("FAIL rnd_read n=%0d a=%h: got %h/%b want %h/1", n, addr_m, d, oe, exp);
                        end
                    end
                end
                default: begin
                    for (int k = 0; k < NUM_IN; k++) in_m[k] = 8'($urandom);
                    drive_inputs();
                    repeat (3) @(negedge cmd_clk);
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       oe;
        do_select(8'h0F);
        do_write(1'b1, 1'b0, 8'h11, 1); model_write(1'b1, 1'b0, 8'h11);
        for (int i = 0; i < NUM_OUT; i++) begin
            do_select(8'(i));
            d = 8'($urandom) | 8'h01;
            do_write(1'b0, 1'b1, d, 1); model_write(1'b0, 1'b1, d);
        end
        do_select(8'(NUM_OUT));
        bus.rb = 1'b1; bus.wc = 1'b1; bus.iv_wdata = 8'h5E;
        for (int k = 1; k <= 4; k++) begin
            @(negedge cmd_clk);
            bus.wc = 1'b0; bus.rb = 1'b0;
        end
        total++; if (strobe !== STROBE_ON) begin bad++; $display("FAIL mid_pulse: got %b want %b", strobe, STROBE_ON); end
        // reset with wc/lb held high across release: no RAM write may result
        rst = 1'b1; bus.lb = 1'b1; bus.wc = 1'b1; bus.iv_wdata = 8'h99;
        @(negedge cmd_clk);
        total++; if (strobe !== 1'b0 || strobe_busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_strobe: got %b%b want 00", strobe, strobe_busy);
        end
        total++; if (addr !== 8'hFF || out_port !== '0 || strobe_data !== 8'h00) begin
            bad++; $display("FAIL mid_rst_state: got a=%h o=%h sd=%h want ff/0/00", addr, out_port, strobe_data);
        end
        total++; if (bus.iv_rdata !== 8'hFF || bus.iv_rdata_oe !== 1'b0) begin
            bad++; $display("FAIL mid_rst_rdata: got %h/%b want ff/0", bus.iv_rdata, bus.iv_rdata_oe);
        end
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge cmd_clk);
        bus.wc = 1'b0; bus.lb = 1'b0;
        @(negedge cmd_clk);
        do_read(1'b1, 1'b0, d, oe);
        total++; if (d !== 8'h11) begin bad++; $display("FAIL no_spurious_write: got %h want 11", d); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_out_port();
        test_in_port();
        test_strobe();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iv_port_bank.md
# iv_port_bank

Parametrised IV-bus peripheral bank for the 8X305 system: one address latch, a left-bank RAM, and a right-bank set of output and input ports, all clocked by `cmd_clk`. It replaces the ad-hoc command latch, one-hot port decode and hand-toggled E strobe with a decoded, registered block. It adds a hardware strobe sequencer that generates setup/pulse/hold timing for HD44780-style or UART peripherals without CPU bit-banging.

## Interface
Parameters:
- `RAM_DEPTH`, 256: left-bank bytes; power of 2, 2..256.
- `NUM_OUT`, 4: output ports, 1..8.
- `NUM_IN`, 2: input ports, 1..8.
- `STROBE_SETUP`, 2: cycles data is stable before the strobe rises; ≥1.
- `STROBE_WIDTH`, 4: strobe high cycles; ≥1.
- `STROBE_HOLD`, 2: cycles after the strobe falls before idle; ≥1.

Ports:
- `cmd_clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `sc`  in  1  select-command: latch the address.
- `wc`  in  1  write-command.
- `lb`  in  1  left-bank (RAM) select.
- `rb`  in  1  right-bank (port) select.
- `iv_wdata`  in  8  bus data, already bit-order corrected.
- `iv_rdata`  out  8  read data.
- `iv_rdata_oe`  out  1  read-data drive enable.
- `in_port`  in  8*NUM_IN  external inputs; asynchronous.
- `out_port`  out  8*NUM_OUT  output port registers.
- `strobe_data`  out  8  byte presented during a strobe cycle.
- `strobe`  out  1  strobe pulse (E).
- `strobe_busy`  out  1  sequencer not idle.
- `addr`  out  8  current latched address.

## Operation
- **Address latch.** When `sc`=1, `addr` <= `iv_wdata`. If `sc` and `wc` are both high in the same cycle, `sc` wins and no write occurs.
- **Write.** A write fires once per `wc` rising edge, detected as `wc`=1 with registered `wc_q`=0. Holding `wc` high never repeats the write.
  - `lb`=1: `RAM[addr % RAM_DEPTH]` <= `iv_wdata`.
  - `lb`=0, `rb`=1, `addr` < `NUM_OUT`: `out_port[addr]` <= data.
  - `rb`=1, `addr` == `NUM_OUT`: strobe trigger.
  - All other right-bank writes, including `addr` ≥ 0x80, are ignored.
  - `lb` has priority over `rb`.
- **Read.** `iv_rdata_oe` = (`lb`|`rb`) & !`sc` & !`wc`, registered.
  - `lb`: RAM byte at `addr`.
  - `rb`, `addr` < `NUM_OUT`: `out_port` readback.
  - `rb`, `addr` == `NUM_OUT`: status = {6'b0, overrun, `strobe_busy`}.
  - `rb`, `addr` == 0x80+k with k < `NUM_IN`: synchronised `in_port[k]`.
  - Otherwise: 0xFF.
- **Input synchronisation.** Each `in_port` passes through a 2-flop synchroniser.
- **Strobe sequencer.** States: IDLE → SETUP (`STROBE_SETUP` cycles) → PULSE (`strobe`=1, `STROBE_WIDTH` cycles) → HOLD (`STROBE_HOLD` cycles) → IDLE.
  - A trigger in IDLE latches `strobe_data` <= `iv_wdata` and enters SETUP on the next edge.
  - `strobe_busy`=1 in every state except IDLE.
  - `strobe_data` is constant from SETUP through HOLD.
  - A trigger while busy is dropped and sets sticky `overrun`. A status read clears `overrun`; if a set and a clear land in the same cycle, set wins.
- **Reset values.**
  - `addr` = 0xFF; `out_port` = all 0x00; `strobe_data` = 0x00.
  - `strobe`, `strobe_busy`, `overrun`, `iv_rdata_oe` = 0; `iv_rdata` = 0xFF.
  - Synchronisers clear; `wc_q` = 1, so no spurious write after reset.
  - RAM contents are not reset.
  - Reset mid-strobe forces IDLE and `strobe`=0 at that edge.

## Timing
- Address to read data: 1 cycle; `iv_rdata` reflects `addr` registered on the previous edge.
- Write to visible state: 1 cycle (`out_port` and RAM update at the `wc`-rise edge).
- `in_port` to readable: 2 cycles + 1 read cycle.
- Strobe trigger to `strobe` rise: 1 + `STROBE_SETUP` cycles. Total busy time = `STROBE_SETUP` + `STROBE_WIDTH` + `STROBE_HOLD` cycles.

## Configuration
- `IV_PORT_STROBE_EN` defined: the strobe sequencer is built as described.
- Undefined:
  - `strobe`, `strobe_busy` and `strobe_data` are tied to 0.
  - Writes to address `NUM_OUT` are ignored.
  - The status register reads 0x00.
  - The `STROBE_*` parameters are unused.

## Structure
- Package `iv_port_pkg`:
  - `IN_BASE` = 8'h80.
  - `RDATA_UNMAPPED` = 8'hFF.
  - Status bit indices `ST_BUSY` = 0, `ST_OVR` = 1.
  - Strobe state enum `strobe_state_t` {IDLE, SETUP, PULSE, HOLD}.
- Sub-module `iv_strobe_seq`: the FSM, down-counter, data latch and overrun flag. It is instantiated only under `IV_PORT_STROBE_EN`.

## Test plan
- `sc` with 0x05; `wc` rise with `lb` and data 0xA5; `lb` read → `iv_rdata`=0xA5 one cycle after read start.
- `sc` 0x02; `rb` `wc` with 0x3C held 5 cycles → `out_port[2]`=0x3C, written exactly once; re-hold shows no extra writes (probe via a counter).
- `in_port[1]`=0x5A; `sc` 0x81, `rb` read → 0x5A three cycles after change; `sc` 0x90 → 0xFF.
- `sc` 4 (`NUM_OUT`=4), `rb` `wc` 0x41 → `strobe_data`=0x41; `strobe` high on cycles 3..6 after trigger; busy clears on cycle 9.
- Second trigger during PULSE → ignored; status read = 0x03, then 0x00 after busy ends and the read clears `overrun`.
- `rst` asserted during PULSE → `strobe`=0, busy=0, `addr`=0xFF, all `out_port`=0x00 at that edge.
